// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and constants for the ram_4x8 port master
package ram_ctrl_pkg;

    localparam int DEF_AW = 3;
    localparam int DEF_DW = 4;

    // Polarity of the RAM rw pin.
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RD_CAP = 2'd2,
        CLEAR  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_4x8_ctrl_if.sv
// rtl/ram_4x8_ctrl_if.sv - request/response bus between a client and ram_4x8_ctrl
interface ram_4x8_ctrl_if
    import ram_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          wr_done;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, wr_done
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, wr_done
    );
endinterface

// File: rtl/ram_4x8.sv
// rtl/ram_4x8.sv - single-port RAM with registered read data (rw: 0 = write, 1 = read)
module ram_4x8 #(
    parameter int AW = 3,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    input  logic          rw,
    output logic [DW-1:0] data_out
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (!rw) begin
            mem[addr] <= data_in;
        end else begin
            data_out <= mem[addr];
        end
    end
endmodule

// File: rtl/ram_4x8_ctrl.sv
// rtl/ram_4x8_ctrl.sv - sequences ram_4x8 pins for handshaked reads/writes and a bulk clear
module ram_4x8_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int            AW        = DEF_AW,
    parameter int            DW        = DEF_DW,
    parameter logic [DW-1:0] CLR_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    ram_4x8_ctrl_if.slave bus,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_rw,
    input  logic [DW-1:0] ram_dout
);
    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t state;

    assign bus.req_ready = (state == IDLE) && !clr_start && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ram_rw        <= RW_READ;
            ram_addr      <= '0;
            ram_din       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.wr_done   <= 1'b0;
            clr_busy      <= 1'b0;
            clr_done      <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.wr_done   <= 1'b0;
            clr_done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clr_start) begin
                        ram_addr <= '0;
                        ram_din  <= CLR_VALUE;
                        ram_rw   <= RW_WRITE;
                        clr_busy <= 1'b1;
                        state    <= CLEAR;
                    end else if (bus.req_valid) begin
                        ram_addr <= bus.req_addr;
                        ram_din  <= bus.req_wdata;
                        ram_rw   <= ~bus.req_wr;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ram_rw still holds the kind of access the RAM performs this edge
                    ram_rw <= RW_READ;
                    if (ram_rw == RW_WRITE) begin
                        bus.wr_done <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= RD_CAP;
                    end
                end
                RD_CAP: begin
                    bus.rsp_data  <= ram_dout;
                    bus.rsp_valid <= 1'b1;
                    state         <= IDLE;
                end
                CLEAR: begin
                    if (ram_addr != LAST_ADDR) begin
                        ram_addr <= ram_addr + AW'(1);
                    end else begin
                        ram_rw   <= RW_READ;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_4x8_ctrl.sv
// tb/tb_ram_4x8_ctrl.sv - randomized self-checking bench for ram_4x8_ctrl with ram_4x8
module tb_ram_4x8_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_start = 1'b0;
    logic       clr_busy, clr_done, ram_rw;
    logic [2:0] ram_addr;
    logic [3:0] ram_din, ram_dout;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] mem [8];
    logic [3:0] last_rd = 4'h0;

    always #5 clk = ~clk;

    ram_4x8_ctrl_if #(.AW(3), .DW(4)) bus ();

    ram_4x8_ctrl #(.AW(3), .DW(4), .CLR_VALUE(4'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_rw    (ram_rw),
        .ram_dout  (ram_dout)
    );

    ram_4x8 #(.AW(3), .DW(4)) u_ram (
        .clk      (clk),
        .addr     (ram_addr),
        .data_in  (ram_din),
        .rw       (ram_rw),
        .data_out (ram_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.req_wr    = 1'($urandom_range(1, 0));
        bus.req_addr  = 3'($urandom_range(7, 0));
        bus.req_wdata = 4'($urandom_range(15, 0));
    endtask

    task automatic idle_bus();
        bus.req_valid = 1'b0;
        scramble();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
        check({tag, "_wr_done"},   32'(bus.wr_done),   32'd0);
        check({tag, "_clr_busy"},  32'(clr_busy),      32'd0);
        check({tag, "_clr_done"},  32'(clr_done),      32'd0);
        check({tag, "_ram_rw"},    32'(ram_rw),        32'd1);
        check({tag, "_ram_addr"},  32'(ram_addr),      32'd0);
        check({tag, "_ram_din"},   32'(ram_din),       32'd0);
    endtask

    // Starts in an accepting cycle, returns in the cycle wr_done is high (next accept point).
    task automatic do_write(input logic [2:0] a, input logic [3:0] d);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        check("wr_rdy", 32'(bus.req_ready), 32'd1);
        step();
        scramble();
        check("wr_rw_low", 32'(ram_rw), 32'd0);
        check("wr_addr", 32'(ram_addr), 32'(a));
        check("wr_din", 32'(ram_din), 32'(d));
        check("wr_no_pulse", 32'({bus.rsp_valid, bus.wr_done}), 32'd0);
        check("wr_busy_rdy", 32'(bus.req_ready), 32'd0);
        step();
        mem[a] = d;
        check("wr_done", 32'(bus.wr_done), 32'd1);
        check("wr_rw_high", 32'(ram_rw), 32'd1);
        check("rsp_hold", 32'(bus.rsp_data), 32'(last_rd));
    endtask

    // Returns in the cycle rsp_valid is high, with req_valid still asserted.
    task automatic do_read(input logic [2:0] a, input bit clr_in_issue);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = a;
        check("rd_rdy", 32'(bus.req_ready), 32'd1);
        step();
        scramble();
        check("rd_rdy_t1", 32'(bus.req_ready), 32'd0);
        check("rd_rw", 32'(ram_rw), 32'd1);
        check("rd_addr", 32'(ram_addr), 32'(a));
        check("rd_no_pulse", 32'({bus.rsp_valid, bus.wr_done}), 32'd0);
        if (clr_in_issue) clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        check("rd_rdy_t2", 32'(bus.req_ready), 32'd0);
        check("rd_no_rsp_t2", 32'(bus.rsp_valid), 32'd0);
        check("rd_clr_busy", 32'(clr_busy), 32'd0);
        step();
        last_rd = mem[a];
        check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_rsp_data", 32'(bus.rsp_data), 32'(last_rd));
        check("rd_rdy_t3", 32'(bus.req_ready), 32'd1);
        check("rd_clr_busy_t3", 32'(clr_busy), 32'd0);
    endtask

    // abort_k = 0: full clear; abort_k = k (1..8): reset during the k-th clear cycle.
    task automatic do_clear(input int abort_k);
        clr_start     = 1'b1;
        bus.req_valid = 1'b1;
        scramble();
        #1;
        check("clr_rdy", 32'(bus.req_ready), 32'd0);
        step();
        clr_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("clr_busy", 32'(clr_busy), 32'd1);
            check("clr_addr", 32'(ram_addr), 32'(k));
            check("clr_rw", 32'(ram_rw), 32'd0);
            check("clr_din", 32'(ram_din), 32'd0);
            check("clr_done_early", 32'(clr_done), 32'd0);
            if (k + 1 == abort_k) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                idle_bus();
                #1;
                for (int j = 0; j < abort_k; j++) mem[j] = 4'h0;
                last_rd = 4'h0;
                check_reset_outputs("clr_abort");
                check("clr_abort_rdy", 32'(bus.req_ready), 32'd1);
                return;
            end
            scramble();
            step();
        end
        for (int j = 0; j < 8; j++) mem[j] = 4'h0;
        check("clr_busy_end", 32'(clr_busy), 32'd0);
        check("clr_done", 32'(clr_done), 32'd1);
        check("clr_rw_end", 32'(ram_rw), 32'd1);
        idle_bus();
        step();
        check("clr_done_pulse", 32'(clr_done), 32'd0);
        check("clr_rdy_end", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        idle_bus();
        step();
        step();
        check_reset_outputs("rst");
        check("rst_rdy", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rel_rdy", 32'(bus.req_ready), 32'd1);

        do_clear(0);

        // single write then read of address 5
        do_write(3'd5, 4'hA);
        idle_bus();
        step();
        check("wr_pulse_len", 32'(bus.wr_done), 32'd0);
        do_read(3'd5, 1'b0);
        idle_bus();
        step();
        check("rsp_pulse_len", 32'(bus.rsp_valid), 32'd0);

        // back-to-back fill and read-back with req_valid held
        for (int i = 0; i < 8; i++) do_write(3'(i), 4'(i) ^ 4'h3);
        for (int i = 0; i < 8; i++) do_read(3'(i), 1'b0);
        idle_bus();
        step();

        // clear then verify every entry
        do_clear(0);
        for (int i = 0; i < 8; i++) do_read(3'(i), 1'b0);
        idle_bus();
        step();

        // clear request during ISSUE of a read is ignored
        do_write(3'd2, 4'h9);
        do_read(3'd2, 1'b1);
        idle_bus();
        step();
        check("clr_ignored", 32'(clr_busy), 32'd0);

        // reset during RD_CAP drops the response
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 3'd2;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_bus();
        #1;
        last_rd = 4'h0;
        check_reset_outputs("rdcap_rst");
        check("rdcap_rst_rdy", 32'(bus.req_ready), 32'd1);
        step();
        check("rdcap_rst_norsp", 32'(bus.rsp_valid), 32'd0);

        // clear aborted in its 4th cycle leaves entries 4..7 intact
        for (int i = 0; i < 8; i++) do_write(3'(i), 4'(i) ^ 4'h3);
        idle_bus();
        step();
        do_clear(4);
        for (int i = 0; i < 8; i++) do_read(3'(i), 1'b0);
        idle_bus();
        step();

        // randomized mix against the array model
        for (int n = 0; n < 120; n++) begin
            int r;
            r = int'($urandom_range(19, 0));
            if (r == 0) do_clear(int'($urandom_range(8, 0)));
            else if (r < 9) do_write(3'($urandom_range(7, 0)), 4'($urandom_range(15, 0)));
            else do_read(3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) begin
                idle_bus();
                step();
            end
        end
        idle_bus();
        step();
        for (int i = 0; i < 8; i++) do_read(3'(i), 1'b0);
        idle_bus();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
